// File: rtl/store_sequencer.sv
// store_sequencer: multi-cycle controller for the store datapath.
// Walks one store request through register read, address generation and
// memory write, rejecting word-misaligned addresses and counting commits.
module store_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [RA_W-1:0]   req_base,
    input  logic [RA_W-1:0]   req_src,
    input  logic [15:0]       req_offset,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [15:0]       sext_in,
    input  logic [ADDR_W-1:0] sext_out,
    output logic [ADDR_W-1:0] alu_a,
    output logic [ADDR_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [ADDR_W-1:0] alu_result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              done,
    output logic              fault,
    output logic [CNT_W-1:0]  store_count
);

    localparam int unsigned OFF_W   = 16;
    localparam logic [2:0]  ALU_ADD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ADDR,
        S_WRITE,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [RA_W-1:0]     base_idx_q, base_idx_d;
    logic [RA_W-1:0]     src_idx_q, src_idx_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                fault_q, fault_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // State and latch registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_idx_q <= '0;
            src_idx_q  <= '0;
            offset_q   <= '0;
            base_q     <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            fault_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_idx_q <= base_idx_d;
            src_idx_q  <= src_idx_d;
            offset_q   <= offset_d;
            base_q     <= base_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            fault_q    <= fault_d;
            count_q    <= count_d;
        end
    end

    // Next-state, latch updates and per-phase datapath control.
    always_comb begin
        state_d    = state_q;
        base_idx_d = base_idx_q;
        src_idx_d  = src_idx_q;
        offset_d   = offset_q;
        base_d     = base_q;
        data_d     = data_q;
        addr_d     = addr_q;
        fault_d    = fault_q;
        count_d    = count_q;

        req_ready  = 1'b0;
        rf_raddr1  = '0;
        rf_raddr2  = '0;
        sext_in    = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = ALU_ADD;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_idx_d = req_base;
                    src_idx_d  = req_src;
                    offset_d   = req_offset;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                rf_raddr1 = base_idx_q;
                rf_raddr2 = src_idx_q;
                base_d    = rf_rdata1;
                data_d    = rf_rdata2;
                state_d   = S_ADDR;
            end
            S_ADDR: begin
                sext_in = offset_q;
                alu_a   = base_q;
                alu_b   = sext_out;
                addr_d  = alu_result;
                // Only word alignment is checked; wrap-around is legal.
                if (alu_result[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    fault_d = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                done  = 1'b1;
                fault = fault_q;
                // Saturate rather than wrap at all-ones.
                if (!fault_q && (count_q != {CNT_W{1'b1}})) begin
                    count_d = count_q + CNT_W'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign store_count = count_q;

endmodule
